store_merge: RTL and testbench

STORE_MERGE -- requirements
Module: store_merge

---
 rtl/store_merge.sv | 77 +++++++
 tb/tb_store_merge.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/store_merge.sv
// store_merge: sub-doubleword store via read-merge-write; clk/reset_n, start/funct3/address/regData request, mem* doubleword port, busy/done/error status
module store_merge (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [63:0] address,
  input  logic [63:0] regData,
  output logic [63:0] memAddress,
  output logic        memRead,
  output logic        memWrite,
  output logic [63:0] memWriteData,
  input  logic [63:0] memReadData,
  input  logic        memReady,
  output logic        busy,
  output logic        done,
  output logic        error
);
  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic [2:0] f3_q, f3_d;
  logic [63:0] addr_q, addr_d, data_q, data_d, merged_q, merged_d, shifted, merged_rd;
  logic [7:0] mask;
  logic legal;
  assign legal = !funct3[2] && (funct3[1] ? (funct3[0] ? address[2:0] == 3'd0 : address[1:0] == 2'd0)
                                          : (!funct3[0] || !address[0]));
  always_comb begin
    mask = (f3_q[1] ? (f3_q[0] ? 8'hFF : 8'h0F) : (f3_q[0] ? 8'h03 : 8'h01)) << addr_q[2:0];
    shifted = data_q << {addr_q[2:0], 3'b000};
    merged_rd = memReadData;
    for (int i = 0; i < 8; i++)
      merged_rd[8*i +: 8] = mask[i] ? shifted[8*i +: 8] : memReadData[8*i +: 8];
  end
  always_comb begin
    state_d = state_q;
    f3_d = f3_q;
    addr_d = addr_q;
    data_d = data_q;
    merged_d = merged_q;
    case (state_q)
      IDLE: if (start) begin
        f3_d = funct3;
        addr_d = address;
        data_d = regData;
        merged_d = regData;
        state_d = !legal ? ERR : funct3 == 3'b011 ? WRITE : READ;
      end
      READ: if (memReady) begin
        merged_d = merged_rd;
        state_d = WRITE;
      end
      WRITE: state_d = memReady ? DONE : WRITE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      f3_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      merged_q <= '0;
    end else begin
      state_q <= state_d;
      f3_q <= f3_d;
      addr_q <= addr_d;
      data_q <= data_d;
      merged_q <= merged_d;
    end
  assign memAddress = {addr_q[63:3], 3'b000};
  assign memWriteData = merged_q;
  assign memRead = state_q == READ;
  assign memWrite = state_q == WRITE;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE || state_q == ERR;
  assign error = state_q == ERR;
endmodule

// File: tb/tb_store_merge.sv
// tb_store_merge: randomized and directed checks of store_merge against a byte-level reference model
module tb_store_merge;
  logic clk = 0, reset_n = 0, start = 0, memReady = 0;
  logic [2:0] funct3 = '0;
  logic [63:0] address = '0, regData = '0, memReadData = '0;
  logic [63:0] memAddress, memWriteData;
  logic memRead, memWrite, busy, done, error;
  int n_chk = 0, n_fail = 0;
  logic [63:0] wd;
  store_merge dut (
    .clk(clk), .reset_n(reset_n), .start(start), .funct3(funct3), .address(address),
    .regData(regData), .memAddress(memAddress), .memRead(memRead), .memWrite(memWrite),
    .memWriteData(memWriteData), .memReadData(memReadData), .memReady(memReady),
    .busy(busy), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit legal(input logic [2:0] f3, input logic [63:0] a);
    return f3 < 3'd4 && (int'(a[2:0]) % (1 << f3)) == 0;
  endfunction
  function automatic logic [63:0] merge(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d, input logic [63:0] md);
    logic [7:0] b[8];
    logic [63:0] r;
    int off;
    off = int'(a[2:0]);
    for (int i = 0; i < 8; i++) b[i] = md[8*i +: 8];
    for (int j = 0; j < (1 << f3) && f3 < 3'd4; j++)
      if (off + j < 8) b[off + j] = d[8*j +: 8];
    for (int i = 0; i < 8; i++) r[8*i +: 8] = b[i];
    return r;
  endfunction
  task automatic run(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d, input logic [63:0] md,
                     input int dly, input bit noise, output logic [63:0] wd_seen);
    bit ok;
    logic [63:0] exp_wd, exp_ma;
    int cyc, rd_cycles, wcnt, exp_cyc;
    ok = legal(f3, a);
    exp_wd = merge(f3, a, d, md);
    exp_ma = {a[63:3], 3'b000};
    exp_cyc = !ok ? 1 : f3 == 3'd3 ? 2 + dly : 3 + 2 * dly;
    cyc = 1;
    rd_cycles = 0;
    wcnt = 0;
    wd_seen = '0;
    @(negedge clk);
    start = 1;
    funct3 = f3;
    address = a;
    regData = d;
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("excl", {63'd0, memRead & memWrite}, 64'd0);
      check("addr", memAddress, exp_ma);
      check("busy", {63'd0, busy}, 64'd1);
      if (!ok) check("noreq", {63'd0, memRead | memWrite}, 64'd0);
      if (memRead) rd_cycles++;
      if (memWrite) begin
        check("wdata", memWriteData, exp_wd);
        wd_seen = memWriteData;
      end
      if (done) begin
        check("error", {63'd0, error}, {63'd0, !ok});
        check("latency", 64'(cyc), 64'(exp_cyc));
        break;
      end
      if (cyc >= 60) begin
        check("timeout", 64'(cyc), 64'(exp_cyc));
        break;
      end
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (start) begin
        funct3 = 3'($urandom);
        address = {$urandom, $urandom};
        regData = {$urandom, $urandom};
      end
      if (memRead || memWrite) begin
        memReady = wcnt == dly;
        wcnt = memReady ? 0 : wcnt + 1;
      end else memReady = 0;
      memReadData = memReady ? md : {$urandom, $urandom};
      cyc++;
    end
    memReady = 0;
    check("rd_cycles", 64'(rd_cycles), (ok && f3 != 3'd3) ? 64'(dly + 1) : 64'd0);
    @(negedge clk);
    start = 0;
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("done_pulse", {63'd0, done}, 64'd0);
  endtask
  initial begin
    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_rw", {62'd0, memRead, memWrite}, 64'd0);
    check("rst_de", {62'd0, done, error}, 64'd0);
    check("rst_wd", memWriteData, 64'd0);
    check("rst_ma", memAddress, 64'd0);
    @(negedge clk);
    reset_n = 1;
    run(3'b000, 64'h1003, 64'hAB, 64'h1122334455667788, 0, 0, wd);
    check("sb_wd", wd, 64'h11223344AB667788);
    run(3'b001, 64'h2006, 64'hBEEF, 64'h0, 0, 0, wd);
    check("sh_wd", wd, 64'hBEEF000000000000);
    run(3'b010, 64'h2004, 64'hDEADBEEF, 64'hFFFFFFFFFFFFFFFF, 0, 0, wd);
    check("sw_wd", wd, 64'hDEADBEEFFFFFFFFF);
    run(3'b011, 64'h3000, 64'h0123456789ABCDEF, 64'h5555, 0, 0, wd);
    check("sd_wd", wd, 64'h0123456789ABCDEF);
    run(3'b010, 64'h4002, 64'h1234, 64'h0, 0, 0, wd);
    run(3'b100, 64'h4000, 64'h1234, 64'h0, 0, 0, wd);
    run(3'b000, 64'h6005, 64'h5A, 64'hCAFEF00DCAFEF00D, 5, 1, wd);
    @(negedge clk);
    start = 1;
    funct3 = 3'b000;
    address = 64'h5001;
    regData = 64'h77;
    @(negedge clk);
    start = 0;
    memReady = 1;
    @(negedge clk);
    memReady = 0;
    check("pre_rst_wr", {63'd0, memWrite}, 64'd1);
    #2 reset_n = 0;
    #1;
    check("arst_rw", {62'd0, memRead, memWrite}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_ma", memAddress, 64'd0);
    check("arst_wd", memWriteData, 64'd0);
    @(negedge clk);
    check("arst_hold", {62'd0, memRead, memWrite}, 64'd0);
    reset_n = 1;
    run(3'b000, 64'h5001, 64'h77, 64'h0102030405060708, 0, 0, wd);
    check("post_rst_wd", wd, 64'h0102030405067708);
    for (int k = 0; k < 60; k++) begin
      logic [2:0] f3;
      logic [63:0] a;
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3[2] = 1'b0;
      a = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0 && f3 < 3'd4) a[2:0] = a[2:0] & ~3'((1 << f3) - 1);
      run(f3, a, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3), 1'($urandom_range(0, 1)), wd);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
